// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - issue/result bundle between the E stage and the multiply/divide controller
interface md_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multi-cycle multiply/divide controller owning HI/LO; MD_MADD_EN adds MADD/MADDU
module md_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        busy_q, busy_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;
    logic [31:0] pend_hi, pend_hi_n, pend_lo, pend_lo_n;

    logic [63:0] prod_s, prod_u, result;
    logic [31:0] abs_a, abs_b, uq, ur, q_s, r_s;
    logic        is_md, is_div;

    assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide on magnitudes: truncation toward zero, remainder follows a.
    // 8000_0000 / -1 falls out naturally as quotient 8000_0000, remainder 0.
    assign abs_a = bus.a[31] ? -bus.a : bus.a;
    assign abs_b = bus.b[31] ? -bus.b : bus.b;
    assign uq    = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign ur    = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign q_s   = (bus.a[31] ^ bus.b[31]) ? -uq : uq;
    assign r_s   = bus.a[31] ? -ur : ur;

    always_comb begin
        result = {hi_q, lo_q};
        is_md  = 1'b0;
        is_div = 1'b0;
        case (bus.op)
            OP_MULT:  begin result = prod_s; is_md = 1'b1; end
            OP_MULTU: begin result = prod_u; is_md = 1'b1; end
            OP_DIV: begin
                is_md  = 1'b1;
                is_div = 1'b1;
                result = (bus.b == 32'd0) ? {bus.a, 32'hFFFF_FFFF} : {r_s, q_s};
            end
            OP_DIVU: begin
                is_md  = 1'b1;
                is_div = 1'b1;
                result = (bus.b == 32'd0) ? {bus.a, 32'hFFFF_FFFF}
                                          : {bus.a % bus.b, bus.a / bus.b};
            end
`ifdef MD_MADD_EN
            OP_MADD:  begin result = {hi_q, lo_q} + prod_s; is_md = 1'b1; end
            OP_MADDU: begin result = {hi_q, lo_q} + prod_u; is_md = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        busy_n    = 1'b0;
        hi_n      = hi_q;
        lo_n      = lo_q;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_md) begin
                        state_n   = BUSY;
                        busy_n    = 1'b1;
                        cnt_n     = is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
                        pend_hi_n = result[63:32];
                        pend_lo_n = result[31:0];
                    end else if (bus.op == OP_MTHI) begin
                        hi_n = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_n = bus.a;
                    end
                end
            end
            BUSY: begin
                // Any start seen here is dropped; the stall unit should never let one through.
                cnt_n  = cnt - 4'd1;
                busy_n = 1'b1;
                if (cnt == 4'd1) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy_q  <= busy_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - scoreboard bench for md_ctrl with default latencies
module tb_md_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_ctrl_if bus ();
    md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (op)
            3'd0: return 64'(sa * sb_);
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic early);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        early = 1'b0;
        while (bus.busy === 1'b1 && lat < 40) begin
            lat++;
            if (bus.hi !== h0 || bus.lo !== l0) early = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd7; bus.b = 32'd0;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        n_checks++;
        if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0 (reset must beat start)", bus.lo); end
    endtask

    task automatic test_spec_ops;
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd9, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd9, 32'd0};
        logic [31:0] elo [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int          elat[5] = '{5, 5, 10, 10, 10};
        int   lat;
        logic early;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{ehi[i], elo[i], elat[i]});
            run_op(ops[i], as[i], bs[i], lat, early);
            e = sb.pop_front();
            n_checks++;
            if (lat != e.lat || early || bus.hi !== e.hi || bus.lo !== e.lo) begin
                n_fail++;
                $display("FAIL spec_op%0d: lat=%0d early=%b hi=%h lo=%h, want lat=%0d early=0 hi=%h lo=%h",
                         i, lat, early, bus.hi, bus.lo, e.lat, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_reset_abort;
        int   lat;
        logic early;
        exp_t e;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd6; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_late_commit: hi=%h lo=%h want 0/0", bus.hi, bus.lo);
        end
        sb.push_back('{32'd0, 32'd5, 0});
        run_op(3'd5, 32'd5, 32'd0, lat, early);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            n_fail++;
            $display("FAIL abort_mtlo: lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        end
    endtask

    task automatic test_start_while_busy;
        int   lat = 0;
        exp_t e;
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.busy === 1'b1 && lat < 40) begin
            lat++;
            bus.start = (lat == 3);
            bus.op = 3'd4;
            bus.a = 32'h1234;
            @(negedge clk);
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            n_fail++;
            $display("FAIL busy_start_ignored: lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        end
    endtask

    task automatic test_madd;
        int   lat;
        logic early;
        exp_t e;
        run_op(3'd4, 32'd0, 32'd0, lat, early);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd0, lat, early);
`ifdef MD_MADD_EN
        sb.push_back('{32'd1, 32'd0, 5});
        run_op(3'd7, 32'd1, 32'd1, lat, early);
`else
        sb.push_back('{32'd0, 32'hFFFF_FFFF, 0});
        run_op(3'd6, 32'd3, 32'd4, lat, early);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            n_fail++;
            $display("FAIL madd_nop: lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        end
        sb.push_back('{32'd0, 32'hFFFF_FFFF, 0});
        run_op(3'd7, 32'd1, 32'd1, lat, early);
`endif
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            n_fail++;
            $display("FAIL maddu: lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                     lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        end
    endtask

    task automatic test_random;
        int          lat;
        logic        early;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] r;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 4) ? 32'd0 : (i == 7) ? 32'hFFFF_FFFF : $urandom;
            if (i == 2) b = 32'd3;
            r  = model(op, a, b);
            sb.push_back('{r[63:32], r[31:0], op[1] ? 10 : 5});
            run_op(op, a, b, lat, early);
            e = sb.pop_front();
            n_checks++;
            if (lat != e.lat || early || bus.hi !== e.hi || bus.lo !== e.lo) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d early=%b hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                         i, op, a, b, lat, early, bus.hi, bus.lo, e.lat, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        test_reset;
        test_spec_ops;
        test_reset_abort;
        test_start_while_busy;
        test_madd;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
